voice_mixer_pwm: RTL

VOICE_MIXER_PWM -- requirements
Module: voice_mixer_pwm

---
 rtl/piano_audio_pkg.sv | 28 ++
 rtl/mix_divider.sv | 80 ++++++++
 rtl/voice_mixer_pwm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/piano_audio_pkg.sv
// Shared widths, FSM encoding and helpers
// for the piano voice mixer.
package piano_audio_pkg;

  localparam int NUM_VOICES = 8;
  localparam int SAMPLE_W   = 8;
  localparam int SUM_W      = 11;
  localparam int PWM_W      = 8;
  localparam int CNT_W      = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [PWM_W-1:0] PWM_ACC_LAST  = 8'd7;
  localparam logic [PWM_W-1:0] PWM_DIV_FIRST = 8'd8;
  localparam logic [PWM_W-1:0] PWM_DIV_LAST  = 8'd18;
  localparam logic [PWM_W-1:0] PWM_TOP       = 8'hFF;

  // Clamp a wide sum to the sample range
  function automatic logic [SAMPLE_W-1:0] sat_sample(
    input logic [SUM_W-1:0] v
  );
    return (|v[SUM_W-1:SAMPLE_W]) ? '1 : v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/mix_divider.sv
// Sequential restoring divider, one quotient
// bit per cycle, SUM_W iterations per start.
module mix_divider
  import piano_audio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SUM_W-1:0]    dividend,
  input  logic [CNT_W-1:0]    divisor,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] quotient
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SUM_W - 1);

  logic [SUM_W-1:0] dvd;
  logic [SUM_W-1:0] q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dsr;
  logic [CNT_W-1:0] iter;
  logic             zero;

  logic [SUM_W-1:0] src_dvd;
  logic [CNT_W-1:0] src_rem;
  logic [CNT_W-1:0] src_dsr;
  logic [CNT_W:0]   trial;
  logic             fits;
  logic [CNT_W-1:0] nrem;

  // One restoring step; the start cycle steps the fresh operands
  always_comb begin
    src_dvd = start ? dividend : dvd;
    src_rem = start ? '0 : rem;
    src_dsr = start ? divisor : dsr;
    trial   = {src_rem, src_dvd[SUM_W-1]};
    fits    = trial >= {1'b0, src_dsr};
    nrem    = fits ? (trial[CNT_W-1:0] - src_dsr)
                   : trial[CNT_W-1:0];
  end

  // Iteration registers and start/busy/done handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd  <= '0;
      q    <= '0;
      rem  <= '0;
      dsr  <= '0;
      iter <= '0;
      zero <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvd  <= dividend << 1;
        rem  <= nrem;
        q    <= {{(SUM_W-1){1'b0}}, fits};
        dsr  <= divisor;
        zero <= (divisor == '0);
        iter <= CNT_W'(1);
        busy <= 1'b1;
      end else if (busy) begin
        dvd  <= dvd << 1;
        rem  <= nrem;
        q    <= {q[SUM_W-2:0], fits};
        iter <= iter + CNT_W'(1);
        if (iter == LAST_ITER) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // An empty voice set averages to silence
  assign quotient = zero ? '0 : sat_sample(q);

endmodule

// File: rtl/voice_mixer_pwm.sv
// Eight-voice mixer: accumulate, average or
// saturate once per PWM period, drive speaker.
module voice_mixer_pwm
  import piano_audio_pkg::*;
#(
  parameter int AVERAGE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   voice_1,
  input  logic [SAMPLE_W-1:0]   voice_2,
  input  logic [SAMPLE_W-1:0]   voice_3,
  input  logic [SAMPLE_W-1:0]   voice_4,
  input  logic [SAMPLE_W-1:0]   voice_5,
  input  logic [SAMPLE_W-1:0]   voice_6,
  input  logic [SAMPLE_W-1:0]   voice_7,
  input  logic [SAMPLE_W-1:0]   voice_8,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  speaker,
  output logic [SAMPLE_W-1:0]   mix,
  output logic                  mix_valid,
  output logic [CNT_W-1:0]      active_count
);

  logic [PWM_W-1:0]    pwm_cnt;
  logic [PWM_W-1:0]    duty;
  logic [1:0]          state;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    count;

  logic [SAMPLE_W-1:0] voices [NUM_VOICES];
  logic [SAMPLE_W-1:0] cur_voice;
  logic                cur_en;
  logic [SUM_W-1:0]    add_term;

  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [SAMPLE_W-1:0] div_quot;
  logic [SAMPLE_W-1:0] result;

  // Select the voice addressed by the low counter bits
  always_comb begin
    voices[0] = voice_1;
    voices[1] = voice_2;
    voices[2] = voice_3;
    voices[3] = voice_4;
    voices[4] = voice_5;
    voices[5] = voice_6;
    voices[6] = voice_7;
    voices[7] = voice_8;
    cur_voice = voices[pwm_cnt[2:0]];
    cur_en    = voice_en[pwm_cnt[2:0]];
    add_term  = cur_en ? SUM_W'(cur_voice) : '0;
  end

  // Free-running PWM counter and per-period duty latch
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == PWM_TOP) duty <= mix;
    end
  end

  // Pass sequencer; entering ACCUM also takes voice 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sum   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pwm_cnt == '0) begin
            sum   <= add_term;
            count <= CNT_W'(cur_en);
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          sum   <= sum + add_term;
          count <= count + CNT_W'(cur_en);
          if (pwm_cnt == PWM_ACC_LAST) state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          if (pwm_cnt == PWM_DIV_LAST) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign div_start = (state == S_DIVIDE) &&
                     (pwm_cnt == PWM_DIV_FIRST) &&
                     !div_busy;

  mix_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sum),
    .divisor  (count),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign result = (AVERAGE != 0) ? div_quot
                                 : sat_sample(sum);

  // Publish the finished mix at the end of DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      mix          <= '0;
      active_count <= '0;
    end else if ((state == S_DONE) && div_done) begin
      mix          <= result;
      active_count <= count;
    end
  end

  assign mix_valid = (state == S_DONE);
  assign speaker   = (pwm_cnt < duty);

endmodule
